// File: rtl/dtree_pkg.sv
// Shared definitions for the decision-tree feature loader: default frame
// geometry, the loader FSM state encoding and a counter-width helper.
package dtree_pkg;

  localparam int NUM_FEAT_DEF = 7;
  localparam int FEAT_W_DEF   = 8;
  localparam int CLASS_W_DEF  = 5;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } loader_state_t;

  // Width of a slot index for n slots; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dtree_feature_loader.sv
// Decision-tree feature loader: collects one frame of NUM_FEAT feature bytes
// from a valid/ready stream, presents them on feat_bus to an external
// combinational classifier, captures its result and holds it until the
// downstream handshake. Malformed frames (s_last early or missing) pulse
// frame_err and are dropped.
// Optional build macro DTREE_LOADER_ERRCNT_EN adds an 8-bit saturating
// frame-error counter on output err_cnt.
//
// state | meaning
// ------+------------------------------------------------------------
// LOAD  | accepting bytes into slot cnt, s_ready=1
// EVAL  | one cycle: feat_bus stable, classifier result captured at edge
// HOLD  | m_valid=1, result held until m_ready
module dtree_feature_loader
  import dtree_pkg::*;
#(
  parameter int NUM_FEAT = NUM_FEAT_DEF,
  parameter int FEAT_W   = FEAT_W_DEF,
  parameter int CLASS_W  = CLASS_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [FEAT_W-1:0]          s_data,
  input  logic                       s_last,
  output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
  input  logic [CLASS_W-1:0]         class_in,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [CLASS_W-1:0]         m_class,
  output logic                       frame_err
`ifdef DTREE_LOADER_ERRCNT_EN
  ,
  output logic [7:0]                 err_cnt
`endif
);

  localparam int              CNT_W    = cnt_width(NUM_FEAT);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_FEAT - 1);

  loader_state_t     state;
  logic [CNT_W-1:0]  cnt;
  logic [FEAT_W-1:0] feat [NUM_FEAT];

  logic xfer;
  logic at_last;
  logic frame_ok;
  logic frame_bad;

  // Transfer qualification and frame-shape decode for the current byte.
  always_comb begin
    xfer      = s_valid && s_ready;
    at_last   = (cnt == LAST_IDX);
    frame_ok  = xfer && s_last && at_last;
    frame_bad = xfer && (s_last != at_last);
  end

  // Loader FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      cnt       <= '0;
      s_ready   <= 1'b1;
      m_valid   <= 1'b0;
      m_class   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        LOAD: begin
          if (frame_ok) begin
            cnt     <= '0;
            s_ready <= 1'b0;
            state   <= EVAL;
          end else if (frame_bad) begin
            // Drop the partial frame; the result registers keep the last
            // good classification.
            cnt       <= '0;
            frame_err <= 1'b1;
          end else if (xfer) begin
            cnt <= cnt + 1'b1;
          end
        end
        EVAL: begin
          m_class <= class_in;
          m_valid <= 1'b1;
          state   <= HOLD;
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= LOAD;
          end
        end
        default: begin
          cnt     <= '0;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
          state   <= LOAD;
        end
      endcase
    end
  end

  // Feature slot registers; only written in LOAD since s_ready gates xfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FEAT; i++) begin
        feat[i] <= '0;
      end
    end else if (xfer) begin
      for (int i = 0; i < NUM_FEAT; i++) begin
        if (cnt == CNT_W'(i)) begin
          feat[i] <= s_data;
        end
      end
    end
  end

  // Pack slots onto the classifier bus, feature 0 in the low bits.
  always_comb begin
    feat_bus = '0;
    for (int i = 0; i < NUM_FEAT; i++) begin
      feat_bus[i*FEAT_W +: FEAT_W] = feat[i];
    end
  end

`ifdef DTREE_LOADER_ERRCNT_EN
  // Saturating count of malformed frames, bumped on the edge that raises
  // frame_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if ((state == LOAD) && frame_bad && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Directed bench for dtree_feature_loader. The classifier is modelled as
// class_in = (feature0 + feature6) mod 32; expected classes are hand-computed.
module tb_dtree_feature_loader;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [55:0] feat_bus;
  logic [4:0]  class_in;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_class;
  logic        frame_err;
`ifdef DTREE_LOADER_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  dtree_feature_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .feat_bus  (feat_bus),
    .class_in  (class_in),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_class   (m_class),
    .frame_err (frame_err)
`ifdef DTREE_LOADER_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [8:0] sum9;
  always_comb begin
    sum9     = {1'b0, feat_bus[7:0]} + {1'b0, feat_bus[55:48]};
    class_in = sum9[4:0];
  end

  typedef struct {
    logic [6:0][7:0] b;
    int              nbytes;
    logic            last_final;
    logic            exp_err;
    logic [4:0]      exp_class;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!s_ready && t < 50) begin
      tick();
      t++;
    end
    if (!s_ready) chk("ready_timeout", {63'd0, s_ready}, 64'd1);
  endtask

  task automatic send_frame(input logic [6:0][7:0] b, input int n, input logic last_final);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = b[i];
      s_last  = (i == n - 1) ? last_final : 1'b0;
      wait_ready();
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called #1 after the last byte's transfer edge.
  task automatic expect_result(input logic [4:0] cls, input logic [55:0] feat);
    chk("eval_m_valid", {63'd0, m_valid}, 64'd0);
    chk("eval_s_ready", {63'd0, s_ready}, 64'd0);
    tick();
    chk("hold_m_valid", {63'd0, m_valid}, 64'd1);
    chk("hold_m_class", {59'd0, m_class}, {59'd0, cls});
    chk("hold_feat_bus", {8'd0, feat_bus}, {8'd0, feat});
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("post_hs_m_valid", {63'd0, m_valid}, 64'd0);
    chk("post_hs_s_ready", {63'd0, s_ready}, 64'd1);
  endtask

  logic [4:0]      last_class;
  logic [6:0][7:0] fr;
  logic [6:0][7:0] frames [3];
  logic [4:0]      fcls   [3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{b: {8'h16,8'h15,8'h14,8'h13,8'h12,8'h11,8'h10}, nbytes: 7, last_final: 1'b1, exp_err: 1'b0, exp_class: 5'h06};
    vecs[1] = '{b: {8'h00,8'h00,8'h00,8'hA3,8'hA2,8'hA1,8'hA0}, nbytes: 4, last_final: 1'b1, exp_err: 1'b1, exp_class: 5'h00};
    vecs[2] = '{b: {8'h07,8'h06,8'h05,8'h04,8'h03,8'h02,8'h01}, nbytes: 7, last_final: 1'b1, exp_err: 1'b0, exp_class: 5'h08};
    vecs[3] = '{b: {8'h26,8'h25,8'h24,8'h23,8'h22,8'h21,8'h20}, nbytes: 7, last_final: 1'b0, exp_err: 1'b1, exp_class: 5'h00};
    vecs[4] = '{b: {8'hFF,8'h33,8'h00,8'hAA,8'h55,8'h00,8'hFF}, nbytes: 7, last_final: 1'b1, exp_err: 1'b0, exp_class: 5'h1E};
    vecs[5] = '{b: {8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h77}, nbytes: 1, last_final: 1'b1, exp_err: 1'b1, exp_class: 5'h00};
    vecs[6] = '{b: {8'hC3,8'h55,8'h44,8'h33,8'h22,8'h11,8'h3C}, nbytes: 7, last_final: 1'b1, exp_err: 1'b0, exp_class: 5'h1F};

    clk = 1'b0; rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b0;
    #12;
    chk("rst_feat_bus", {8'd0, feat_bus}, 64'd0);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_m_class", {59'd0, m_class}, 64'd0);
    chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_s_ready", {63'd0, s_ready}, 64'd1);

    // Table of good and malformed frames.
    last_class = 5'h00;
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].b, vecs[v].nbytes, vecs[v].last_final);
      if (vecs[v].exp_err) begin
        chk("err_pulse", {63'd0, frame_err}, 64'd1);
        chk("err_no_m_valid", {63'd0, m_valid}, 64'd0);
        chk("err_m_class_kept", {59'd0, m_class}, {59'd0, last_class});
        tick();
        chk("err_single_pulse", {63'd0, frame_err}, 64'd0);
        chk("err_still_load", {63'd0, s_ready}, 64'd1);
      end else begin
        expect_result(vecs[v].exp_class, vecs[v].b);
        last_class = vecs[v].exp_class;
      end
    end

    // Long HOLD stall with a pending upstream byte that must not be consumed.
    fr = {8'h0C,8'h06,8'h05,8'h04,8'h03,8'h02,8'h21};
    send_frame(fr, 7, 1'b1);
    s_valid = 1'b1; s_data = 8'h40; s_last = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("stall_m_valid", {63'd0, m_valid}, 64'd1);
      chk("stall_m_class", {59'd0, m_class}, 64'h0D);
      chk("stall_feat_bus", {8'd0, feat_bus}, {8'd0, fr});
      chk("stall_s_ready", {63'd0, s_ready}, 64'd0);
      tick();
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    fr = {8'h06,8'h05,8'h04,8'h03,8'h02,8'h01,8'h40};
    send_frame(fr, 7, 1'b1);
    expect_result(5'h06, fr);

    // Asynchronous reset mid-frame.
    fr = {8'h00,8'h00,8'h00,8'h00,8'h93,8'h92,8'h91};
    send_frame(fr, 3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("amid_feat_bus", {8'd0, feat_bus}, 64'd0);
    chk("amid_m_valid", {63'd0, m_valid}, 64'd0);
    chk("amid_frame_err", {63'd0, frame_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("amid_no_err", {63'd0, frame_err}, 64'd0);
    fr = {8'h16,8'h15,8'h14,8'h13,8'h12,8'h11,8'h10};
    send_frame(fr, 7, 1'b1);
    expect_result(5'h06, fr);

    // Asynchronous reset while holding a result.
    fr = {8'hC3,8'h55,8'h44,8'h33,8'h22,8'h11,8'h3C};
    send_frame(fr, 7, 1'b1);
    tick();
    chk("ahold_pre_m_valid", {63'd0, m_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ahold_m_valid", {63'd0, m_valid}, 64'd0);
    chk("ahold_m_class", {59'd0, m_class}, 64'd0);
    chk("ahold_feat_bus", {8'd0, feat_bus}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ahold_no_err", {63'd0, frame_err}, 64'd0);
    chk("ahold_s_ready", {63'd0, s_ready}, 64'd1);
    fr = {8'h07,8'h06,8'h05,8'h04,8'h03,8'h02,8'h01};
    send_frame(fr, 7, 1'b1);
    expect_result(5'h08, fr);

    // Continuous streaming with m_ready held high: one result per 9 cycles.
    frames[0] = {8'h36,8'h35,8'h34,8'h33,8'h32,8'h31,8'h30}; fcls[0] = 5'h06;
    frames[1] = {8'h47,8'h46,8'h45,8'h44,8'h43,8'h42,8'h41}; fcls[1] = 5'h08;
    frames[2] = {8'h6A,8'h55,8'h54,8'h53,8'h52,8'h51,8'h50}; fcls[2] = 5'h1A;
    begin
      int idx = 0;
      int t = 0;
      int nres = 0;
      int last_t = 0;
      logic rdy;
      m_ready = 1'b1;
      while (nres < 3 && t < 100) begin
        if (idx < 21) begin
          s_valid = 1'b1;
          s_data  = frames[idx / 7][idx % 7];
          s_last  = ((idx % 7) == 6);
        end else begin
          s_valid = 1'b0;
          s_last  = 1'b0;
        end
        rdy = s_ready;
        tick();
        t++;
        if (rdy && s_valid) idx++;
        if (m_valid) begin
          chk("stream_class", {59'd0, m_class}, {59'd0, fcls[nres]});
          chk("stream_feat", {8'd0, feat_bus}, {8'd0, frames[nres]});
          if (nres > 0) chk("stream_period", 64'(t - last_t), 64'd9);
          last_t = t;
          nres++;
        end
      end
      m_ready = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk("stream_results", 64'(nres), 64'd3);
      chk("stream_bytes", 64'(idx), 64'd21);
      chk("stream_no_err", {63'd0, frame_err}, 64'd0);
    end

`ifdef DTREE_LOADER_ERRCNT_EN
    tick();
    chk("errcnt_after_reset", {56'd0, err_cnt}, 64'd0);
    s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("errcnt_10", {56'd0, err_cnt}, 64'd10);
    for (int k = 0; k < 290; k++) tick();
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    chk("errcnt_sat", {56'd0, err_cnt}, 64'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
